// File: rtl/ctrl_bus_if.sv
// Controller <-> datapath bundle for path_ctrl_mw: opcode/ready in, mux selects,
// enables, trap status and the retired count out.
interface ctrl_bus_if #(
    parameter int unsigned RETIRE_W = 32
) (
    input logic clk,
    input logic reset
);
    logic [5:0]          op;
    logic                mem_ready;
    logic                i_or_d;
    logic [1:0]          pc_src;
    logic [1:0]          reg_dst;
    logic [1:0]          mem_to_reg;
    logic                alu_srcA;
    logic [1:0]          alu_srcB;
    logic [1:0]          alu_op;
    logic                imm_zext;
    logic                ireg_enab;
    logic                pc_write;
    logic                branch;
    logic                branch_ne;
    logic                reg_write;
    logic                mem_req;
    logic                mem_we;
    logic                exc;
    logic [1:0]          exc_cause;
    logic [RETIRE_W-1:0] retired;

    modport central (
        input  clk, reset, op, mem_ready,
        output i_or_d, pc_src, reg_dst, mem_to_reg, alu_srcA, alu_srcB, alu_op,
               imm_zext, ireg_enab, pc_write, branch, branch_ne, reg_write,
               mem_req, mem_we, exc, exc_cause, retired
    );

    modport datapath (
        input  clk, reset, i_or_d, pc_src, reg_dst, mem_to_reg, alu_srcA, alu_srcB,
               alu_op, imm_zext, ireg_enab, pc_write, branch, branch_ne, reg_write,
               mem_req, mem_we, exc, exc_cause, retired,
        output op, mem_ready
    );
endinterface

// File: rtl/path_ctrl_mw.sv
// Multicycle MIPS main controller with memory wait states, bus timeout,
// optional BNE/ORI/JAL decode, trap state and retired-instruction counter.
module path_ctrl_mw #(
    parameter int unsigned MEM_WAIT      = 0,
    parameter int unsigned USE_MEM_READY = 0,
    parameter int unsigned TIMEOUT       = 16,
    parameter int unsigned EXT_ISA       = 1,
    parameter int unsigned RETIRE_W      = 32
) (
    ctrl_bus_if.central ctrl_bus
);
    localparam int unsigned CNT_MAX = (MEM_WAIT > TIMEOUT) ? MEM_WAIT : TIMEOUT;
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_TO_REG, S_MEM_WRITE,
        S_EXECUTE, S_ALU_TO_REG, S_BRANCH, S_IMM_EXEC, S_IMM_TO_REG,
        S_JUMP, S_JAL, S_TRAP
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [RETIRE_W-1:0] r_retired;
    logic [1:0]          r_cause;

    state_t              w_next;
    logic [1:0]          w_cause_next;
    logic                w_access;
    logic                w_done;
    logic                w_tmo;
    logic                w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
    logic                w_is_addi, w_is_ori, w_is_j, w_is_jal;

    assign w_is_r    = (ctrl_bus.op == 6'd0);
    assign w_is_lw   = (ctrl_bus.op == 6'd35);
    assign w_is_sw   = (ctrl_bus.op == 6'd43);
    assign w_is_beq  = (ctrl_bus.op == 6'd4);
    assign w_is_addi = (ctrl_bus.op == 6'd8);
    assign w_is_j    = (ctrl_bus.op == 6'd2);
    assign w_is_bne  = (EXT_ISA != 0) && (ctrl_bus.op == 6'd5);
    assign w_is_ori  = (EXT_ISA != 0) && (ctrl_bus.op == 6'd13);
    assign w_is_jal  = (EXT_ISA != 0) && (ctrl_bus.op == 6'd3);

    assign w_access = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    assign w_done   = (USE_MEM_READY != 0) ? ctrl_bus.mem_ready : (r_cnt == CW'(MEM_WAIT));
    // A ready arriving in the last allowed cycle completes the access instead of trapping.
    assign w_tmo    = (USE_MEM_READY != 0) && w_access && !ctrl_bus.mem_ready
                      && (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next       = r_state;
        w_cause_next = 2'b01;
        case (r_state)
            S_FETCH: begin
                if (w_tmo) begin
                    w_next       = S_TRAP;
                    w_cause_next = 2'b10;
                end else if (w_done) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_r)                   w_next = S_EXECUTE;
                else if (w_is_lw || w_is_sw)  w_next = S_MEM_ADDR;
                else if (w_is_beq || w_is_bne) w_next = S_BRANCH;
                else if (w_is_addi || w_is_ori) w_next = S_IMM_EXEC;
                else if (w_is_j)              w_next = S_JUMP;
                else if (w_is_jal)            w_next = S_JAL;
                else                          w_next = S_TRAP;
            end
            S_MEM_ADDR:   w_next = w_is_lw ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (w_tmo) begin
                    w_next       = S_TRAP;
                    w_cause_next = 2'b10;
                end else if (w_done) begin
                    w_next = S_MEM_TO_REG;
                end
            end
            S_MEM_WRITE: begin
                if (w_tmo) begin
                    w_next       = S_TRAP;
                    w_cause_next = 2'b10;
                end else if (w_done) begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_TO_REG: w_next = S_FETCH;
            S_EXECUTE:    w_next = S_ALU_TO_REG;
            S_ALU_TO_REG: w_next = S_FETCH;
            S_BRANCH:     w_next = S_FETCH;
            S_IMM_EXEC:   w_next = S_IMM_TO_REG;
            S_IMM_TO_REG: w_next = S_FETCH;
            S_JUMP:       w_next = S_FETCH;
            S_JAL:        w_next = S_FETCH;
            S_TRAP:       w_next = S_FETCH;
            default:      w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
        if (ctrl_bus.reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_retired <= '0;
            r_cause   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_access)
                r_cnt <= r_cnt + 1'b1;
            if ((w_next == S_TRAP) && (r_state != S_TRAP))
                r_cause <= w_cause_next;
            if ((w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP))
                r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    // Decoded straight from state (and done) so reset kills enables asynchronously.
    always_comb begin
        ctrl_bus.i_or_d     = 1'b0;
        ctrl_bus.pc_src     = 2'b00;
        ctrl_bus.reg_dst    = 2'b00;
        ctrl_bus.mem_to_reg = 2'b00;
        ctrl_bus.alu_srcA   = 1'b0;
        ctrl_bus.alu_srcB   = 2'b00;
        ctrl_bus.alu_op     = 2'b00;
        ctrl_bus.imm_zext   = 1'b0;
        ctrl_bus.ireg_enab  = 1'b0;
        ctrl_bus.pc_write   = 1'b0;
        ctrl_bus.branch     = 1'b0;
        ctrl_bus.branch_ne  = 1'b0;
        ctrl_bus.reg_write  = 1'b0;
        ctrl_bus.mem_req    = 1'b0;
        ctrl_bus.mem_we     = 1'b0;
        ctrl_bus.exc        = 1'b0;
        if (!ctrl_bus.reset) begin
            case (r_state)
                S_FETCH: begin
                    ctrl_bus.mem_req   = 1'b1;
                    ctrl_bus.alu_srcB  = 2'b01;
                    ctrl_bus.ireg_enab = w_done;
                    ctrl_bus.pc_write  = w_done;
                end
                S_DECODE:   ctrl_bus.alu_srcB = 2'b11;
                S_MEM_ADDR: begin
                    ctrl_bus.alu_srcA = 1'b1;
                    ctrl_bus.alu_srcB = 2'b10;
                end
                S_MEM_READ: begin
                    ctrl_bus.i_or_d  = 1'b1;
                    ctrl_bus.mem_req = 1'b1;
                end
                S_MEM_TO_REG: begin
                    ctrl_bus.mem_to_reg = 2'b01;
                    ctrl_bus.reg_write  = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl_bus.i_or_d  = 1'b1;
                    ctrl_bus.mem_req = 1'b1;
                    ctrl_bus.mem_we  = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl_bus.alu_srcA = 1'b1;
                    ctrl_bus.alu_op   = 2'b10;
                end
                S_ALU_TO_REG: begin
                    ctrl_bus.reg_dst   = 2'b01;
                    ctrl_bus.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    ctrl_bus.alu_srcA  = 1'b1;
                    ctrl_bus.alu_op    = 2'b01;
                    ctrl_bus.pc_src    = 2'b01;
                    ctrl_bus.branch    = w_is_beq;
                    ctrl_bus.branch_ne = w_is_bne;
                end
                S_IMM_EXEC: begin
                    ctrl_bus.alu_srcA = 1'b1;
                    ctrl_bus.alu_srcB = 2'b10;
                    ctrl_bus.alu_op   = w_is_ori ? 2'b11 : 2'b00;
                    ctrl_bus.imm_zext = w_is_ori;
                end
                S_IMM_TO_REG: ctrl_bus.reg_write = 1'b1;
                S_JUMP: begin
                    ctrl_bus.pc_src   = 2'b10;
                    ctrl_bus.pc_write = 1'b1;
                end
                S_JAL: begin
                    ctrl_bus.pc_src     = 2'b10;
                    ctrl_bus.pc_write   = 1'b1;
                    ctrl_bus.reg_dst    = 2'b10;
                    ctrl_bus.mem_to_reg = 2'b10;
                    ctrl_bus.reg_write  = 1'b1;
                end
                S_TRAP: begin
                    ctrl_bus.pc_src   = 2'b11;
                    ctrl_bus.pc_write = 1'b1;
                    ctrl_bus.exc      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ctrl_bus.exc_cause = r_cause;
    assign ctrl_bus.retired   = r_retired;
endmodule

// File: tb/tb_path_ctrl_mw.sv
// Directed bench for path_ctrl_mw: four configurations, per-cycle expected
// control words from a vector table plus hand-written wait/timeout/reset sequences.
module tb_path_ctrl_mw;
    typedef struct packed {
        logic       i_or_d;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_srcA;
        logic [1:0] alu_srcB;
        logic [1:0] alu_op;
        logic       imm_zext;
        logic       ireg_enab;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       reg_write;
        logic       mem_req;
        logic       mem_we;
        logic       exc;
    } out_t;

    typedef struct {
        logic [5:0]  op;
        out_t        exp;
        logic [31:0] ret;
        logic [1:0]  cause;
        string       name;
    } vec_t;

    localparam out_t O_ZERO  = '0;
    localparam out_t O_FETCH = '{alu_srcB: 2'b01, ireg_enab: 1'b1, pc_write: 1'b1, mem_req: 1'b1, default: '0};
    localparam out_t O_FWAIT = '{alu_srcB: 2'b01, mem_req: 1'b1, default: '0};
    localparam out_t O_DEC   = '{alu_srcB: 2'b11, default: '0};
    localparam out_t O_MADDR = '{alu_srcA: 1'b1, alu_srcB: 2'b10, default: '0};
    localparam out_t O_MRD   = '{i_or_d: 1'b1, mem_req: 1'b1, default: '0};
    localparam out_t O_M2R   = '{mem_to_reg: 2'b01, reg_write: 1'b1, default: '0};
    localparam out_t O_MWR   = '{i_or_d: 1'b1, mem_req: 1'b1, mem_we: 1'b1, default: '0};
    localparam out_t O_EXE   = '{alu_srcA: 1'b1, alu_op: 2'b10, default: '0};
    localparam out_t O_A2R   = '{reg_dst: 2'b01, reg_write: 1'b1, default: '0};
    localparam out_t O_BEQ   = '{alu_srcA: 1'b1, alu_op: 2'b01, pc_src: 2'b01, branch: 1'b1, default: '0};
    localparam out_t O_BNE   = '{alu_srcA: 1'b1, alu_op: 2'b01, pc_src: 2'b01, branch_ne: 1'b1, default: '0};
    localparam out_t O_ORI   = '{alu_srcA: 1'b1, alu_srcB: 2'b10, alu_op: 2'b11, imm_zext: 1'b1, default: '0};
    localparam out_t O_ADDI  = '{alu_srcA: 1'b1, alu_srcB: 2'b10, default: '0};
    localparam out_t O_WB    = '{reg_write: 1'b1, default: '0};
    localparam out_t O_JMP   = '{pc_src: 2'b10, pc_write: 1'b1, default: '0};
    localparam out_t O_JAL   = '{pc_src: 2'b10, pc_write: 1'b1, reg_dst: 2'b10, mem_to_reg: 2'b10, reg_write: 1'b1, default: '0};
    localparam out_t O_TRAP  = '{pc_src: 2'b11, pc_write: 1'b1, exc: 1'b1, default: '0};

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    ctrl_bus_if #(.RETIRE_W(32)) bus_a (.clk(clk), .reset(rst_a));
    ctrl_bus_if #(.RETIRE_W(32)) bus_b (.clk(clk), .reset(rst_b));
    ctrl_bus_if #(.RETIRE_W(32)) bus_c (.clk(clk), .reset(rst_c));
    ctrl_bus_if #(.RETIRE_W(32)) bus_d (.clk(clk), .reset(rst_d));

    path_ctrl_mw #(.MEM_WAIT(0), .USE_MEM_READY(0), .TIMEOUT(16), .EXT_ISA(1), .RETIRE_W(32))
        u_a (.ctrl_bus(bus_a));
    path_ctrl_mw #(.MEM_WAIT(2), .USE_MEM_READY(0), .TIMEOUT(16), .EXT_ISA(1), .RETIRE_W(32))
        u_b (.ctrl_bus(bus_b));
    path_ctrl_mw #(.MEM_WAIT(0), .USE_MEM_READY(1), .TIMEOUT(4), .EXT_ISA(1), .RETIRE_W(32))
        u_c (.ctrl_bus(bus_c));
    path_ctrl_mw #(.MEM_WAIT(0), .USE_MEM_READY(0), .TIMEOUT(16), .EXT_ISA(0), .RETIRE_W(32))
        u_d (.ctrl_bus(bus_d));

    out_t got_a, got_b, got_c, got_d;
    assign got_a = {bus_a.i_or_d, bus_a.pc_src, bus_a.reg_dst, bus_a.mem_to_reg, bus_a.alu_srcA,
                    bus_a.alu_srcB, bus_a.alu_op, bus_a.imm_zext, bus_a.ireg_enab, bus_a.pc_write,
                    bus_a.branch, bus_a.branch_ne, bus_a.reg_write, bus_a.mem_req, bus_a.mem_we, bus_a.exc};
    assign got_b = {bus_b.i_or_d, bus_b.pc_src, bus_b.reg_dst, bus_b.mem_to_reg, bus_b.alu_srcA,
                    bus_b.alu_srcB, bus_b.alu_op, bus_b.imm_zext, bus_b.ireg_enab, bus_b.pc_write,
                    bus_b.branch, bus_b.branch_ne, bus_b.reg_write, bus_b.mem_req, bus_b.mem_we, bus_b.exc};
    assign got_c = {bus_c.i_or_d, bus_c.pc_src, bus_c.reg_dst, bus_c.mem_to_reg, bus_c.alu_srcA,
                    bus_c.alu_srcB, bus_c.alu_op, bus_c.imm_zext, bus_c.ireg_enab, bus_c.pc_write,
                    bus_c.branch, bus_c.branch_ne, bus_c.reg_write, bus_c.mem_req, bus_c.mem_we, bus_c.exc};
    assign got_d = {bus_d.i_or_d, bus_d.pc_src, bus_d.reg_dst, bus_d.mem_to_reg, bus_d.alu_srcA,
                    bus_d.alu_srcB, bus_d.alu_op, bus_d.imm_zext, bus_d.ireg_enab, bus_d.pc_write,
                    bus_d.branch, bus_d.branch_ne, bus_d.reg_write, bus_d.mem_req, bus_d.mem_we, bus_d.exc};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_bus(input int idx, input string name, input out_t exp,
                           input logic [31:0] ret, input logic [1:0] cause);
        out_t        g;
        logic [31:0] r;
        logic [1:0]  c;
        case (idx)
            0:       begin g = got_a; r = bus_a.retired; c = bus_a.exc_cause; end
            1:       begin g = got_b; r = bus_b.retired; c = bus_b.exc_cause; end
            2:       begin g = got_c; r = bus_c.retired; c = bus_c.exc_cause; end
            default: begin g = got_d; r = bus_d.retired; c = bus_d.exc_cause; end
        endcase
        chk({name, " outputs"}, 64'(g), 64'(exp));
        chk({name, " retired"}, 64'(r), 64'(ret));
        chk({name, " exc_cause"}, 64'(c), 64'(cause));
    endtask

    task automatic drive(input int idx, input logic [5:0] op, input logic mr);
        case (idx)
            0:       begin bus_a.op = op; bus_a.mem_ready = mr; end
            1:       begin bus_b.op = op; bus_b.mem_ready = mr; end
            2:       begin bus_c.op = op; bus_c.mem_ready = mr; end
            default: begin bus_d.op = op; bus_d.mem_ready = mr; end
        endcase
    endtask

    // Called just after a falling edge: apply inputs, check, move to next falling edge.
    task automatic step(input int idx, input string name, input logic [5:0] op, input logic mr,
                        input out_t exp, input logic [31:0] ret, input logic [1:0] cause);
        drive(idx, op, mr);
        #1;
        chk_bus(idx, name, exp, ret, cause);
        @(negedge clk);
    endtask

    task automatic add(input string name, input logic [5:0] op, input out_t exp,
                       input logic [31:0] ret, input logic [1:0] cause);
        vec_t v;
        v.name = name; v.op = op; v.exp = exp; v.ret = ret; v.cause = cause;
        vq.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) drive(i, 6'd0, 1'b0);

        add("lw fetch", 6'd35, O_FETCH, 0, 2'b00);
        add("lw decode", 6'd35, O_DEC, 0, 2'b00);
        add("lw mem_addr", 6'd35, O_MADDR, 0, 2'b00);
        add("lw mem_read", 6'd35, O_MRD, 0, 2'b00);
        add("lw mem_to_reg", 6'd35, O_M2R, 0, 2'b00);
        add("sw fetch", 6'd43, O_FETCH, 1, 2'b00);
        add("sw decode", 6'd43, O_DEC, 1, 2'b00);
        add("sw mem_addr", 6'd43, O_MADDR, 1, 2'b00);
        add("sw mem_write", 6'd43, O_MWR, 1, 2'b00);
        add("r fetch", 6'd0, O_FETCH, 2, 2'b00);
        add("r decode", 6'd0, O_DEC, 2, 2'b00);
        add("r execute", 6'd0, O_EXE, 2, 2'b00);
        add("r alu_to_reg", 6'd0, O_A2R, 2, 2'b00);
        add("bne fetch", 6'd5, O_FETCH, 3, 2'b00);
        add("bne decode", 6'd5, O_DEC, 3, 2'b00);
        add("bne branch", 6'd5, O_BNE, 3, 2'b00);
        add("beq fetch", 6'd4, O_FETCH, 4, 2'b00);
        add("beq decode", 6'd4, O_DEC, 4, 2'b00);
        add("beq branch", 6'd4, O_BEQ, 4, 2'b00);
        add("ori fetch", 6'd13, O_FETCH, 5, 2'b00);
        add("ori decode", 6'd13, O_DEC, 5, 2'b00);
        add("ori imm_exec", 6'd13, O_ORI, 5, 2'b00);
        add("ori imm_to_reg", 6'd13, O_WB, 5, 2'b00);
        add("addi fetch", 6'd8, O_FETCH, 6, 2'b00);
        add("addi decode", 6'd8, O_DEC, 6, 2'b00);
        add("addi imm_exec", 6'd8, O_ADDI, 6, 2'b00);
        add("addi imm_to_reg", 6'd8, O_WB, 6, 2'b00);
        add("j fetch", 6'd2, O_FETCH, 7, 2'b00);
        add("j decode", 6'd2, O_DEC, 7, 2'b00);
        add("j jump", 6'd2, O_JMP, 7, 2'b00);
        add("jal fetch", 6'd3, O_FETCH, 8, 2'b00);
        add("jal decode", 6'd3, O_DEC, 8, 2'b00);
        add("jal jal", 6'd3, O_JAL, 8, 2'b00);
        add("badop fetch", 6'd63, O_FETCH, 9, 2'b00);
        add("badop decode", 6'd63, O_DEC, 9, 2'b00);
        add("badop trap", 6'd63, O_TRAP, 9, 2'b01);
        add("post-trap fetch", 6'd0, O_FETCH, 9, 2'b01);

        // Reset held: every enable low even though the state is FETCH.
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(i, 6'd35, 1'b1);
            #1;
            chk_bus(i, "in reset", O_ZERO, 0, 2'b00);
        end
        @(negedge clk);

        // Default configuration, one instruction of each kind.
        rst_a = 1'b0;
        for (int i = 0; i < vq.size(); i++)
            step(0, vq[i].name, vq[i].op, 1'b0, vq[i].exp, vq[i].ret, vq[i].cause);

        // MEM_WAIT=2: fetch stretches to three cycles, enables only on the last.
        rst_b = 1'b0;
        step(1, "w2 fetch c1", 6'd8, 1'b0, O_FWAIT, 0, 2'b00);
        step(1, "w2 fetch c2", 6'd8, 1'b0, O_FWAIT, 0, 2'b00);
        step(1, "w2 fetch c3", 6'd8, 1'b0, O_FETCH, 0, 2'b00);
        step(1, "w2 decode", 6'd8, 1'b0, O_DEC, 0, 2'b00);
        step(1, "w2 imm_exec", 6'd8, 1'b0, O_ADDI, 0, 2'b00);
        step(1, "w2 imm_to_reg", 6'd8, 1'b0, O_WB, 0, 2'b00);
        step(1, "w2 next fetch", 6'd8, 1'b0, O_FWAIT, 1, 2'b00);

        // Ready handshake, TIMEOUT=4: store never acknowledged -> trap.
        rst_c = 1'b0;
        step(2, "rdy fetch", 6'd43, 1'b1, O_FETCH, 0, 2'b00);
        step(2, "rdy decode", 6'd43, 1'b0, O_DEC, 0, 2'b00);
        step(2, "rdy mem_addr", 6'd43, 1'b0, O_MADDR, 0, 2'b00);
        for (int i = 0; i < 4; i++)
            step(2, "tmo mem_write", 6'd43, 1'b0, O_MWR, 0, 2'b00);
        step(2, "tmo trap", 6'd43, 1'b0, O_TRAP, 0, 2'b10);
        step(2, "tmo fetch", 6'd43, 1'b1, O_FETCH, 0, 2'b10);
        // Same store, ready on the last permitted cycle completes it.
        step(2, "rdy2 decode", 6'd43, 1'b0, O_DEC, 0, 2'b10);
        step(2, "rdy2 mem_addr", 6'd43, 1'b0, O_MADDR, 0, 2'b10);
        for (int i = 0; i < 3; i++)
            step(2, "rdy2 mem_write wait", 6'd43, 1'b0, O_MWR, 0, 2'b10);
        step(2, "rdy2 mem_write last", 6'd43, 1'b1, O_MWR, 0, 2'b10);
        step(2, "rdy2 fetch wait", 6'd43, 1'b0, O_FWAIT, 1, 2'b10);

        // Reset asserted in the middle of a write wait.
        step(2, "rst fetch", 6'd43, 1'b1, O_FETCH, 1, 2'b10);
        step(2, "rst decode", 6'd43, 1'b0, O_DEC, 1, 2'b10);
        step(2, "rst mem_addr", 6'd43, 1'b0, O_MADDR, 1, 2'b10);
        drive(2, 6'd43, 1'b0);
        #1;
        chk_bus(2, "rst mem_write", O_MWR, 1, 2'b10);
        #1;
        rst_c = 1'b1;
        #1;
        chk_bus(2, "rst async", O_ZERO, 0, 2'b00);
        @(negedge clk);
        rst_c = 1'b0;
        step(2, "rst released", 6'd43, 1'b0, O_FWAIT, 0, 2'b00);

        // EXT_ISA=0: BNE opcode is illegal.
        rst_d = 1'b0;
        step(3, "noext fetch", 6'd5, 1'b0, O_FETCH, 0, 2'b00);
        step(3, "noext decode", 6'd5, 1'b0, O_DEC, 0, 2'b00);
        step(3, "noext trap", 6'd5, 1'b0, O_TRAP, 0, 2'b01);
        step(3, "noext fetch2", 6'd5, 1'b0, O_FETCH, 0, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
